adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle 1027-bit add/subtract datapath between two requesters. It sits between the datapath's start/subtract/operand/done interface and two independent requester ports, each with a valid/ready request channel and a valid/ready response channel. It owns operand registration, start generation, completion tracking, a completion watchdog and response buffering, so requesters never drive the datapath directly.

---
 rtl/adder_arbiter.sv | 145 ++++++++++++++
 tb/tb_adder_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one multi-cycle add/subtract datapath between two
// requesters, with operand registration, a completion watchdog and a buffered response.
module adder_arbiter #(
    parameter int unsigned OPW     = 1027,
    parameter int unsigned RESW    = 1028,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic            r0_req_sub,
    input  logic [OPW-1:0]  r0_req_a,
    input  logic [OPW-1:0]  r0_req_b,
    output logic            r0_rsp_valid,
    input  logic            r0_rsp_ready,
    output logic [RESW-1:0] r0_rsp_result,
    output logic            r0_rsp_err,

    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic            r1_req_sub,
    input  logic [OPW-1:0]  r1_req_a,
    input  logic [OPW-1:0]  r1_req_b,
    output logic            r1_rsp_valid,
    input  logic            r1_rsp_ready,
    output logic [RESW-1:0] r1_rsp_result,
    output logic            r1_rsp_err,

    output logic            dp_start,
    output logic            dp_subtract,
    output logic [OPW-1:0]  dp_a,
    output logic [OPW-1:0]  dp_b,
    input  logic [RESW-1:0] dp_result,
    input  logic            dp_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            stateQ, stateD;
    logic              ownerQ, ownerD;
    logic              lastGrantQ, lastGrantD;
    logic [CW-1:0]     cntQ, cntD;
    logic [RESW-1:0]   resultQ, resultD;
    logic              errQ, errD;
    logic              subQ, subD;
    logic [OPW-1:0]    aQ, aD, bQ, bD;
    logic              grant0, grant1;
    logic              ownerRspReady;

    assign ownerRspReady = ownerQ ? r1_rsp_ready : r0_rsp_ready;

    always_comb begin
        stateD     = stateQ;
        ownerD     = ownerQ;
        lastGrantD = lastGrantQ;
        cntD       = cntQ;
        resultD    = resultQ;
        errD       = errQ;
        subD       = subQ;
        aD         = aQ;
        bD         = bQ;
        grant0     = 1'b0;
        grant1     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                // On a tie the port that did not win last time goes first.
                grant0 = r0_req_valid & (~r1_req_valid | lastGrantQ);
                grant1 = r1_req_valid & (~r0_req_valid | ~lastGrantQ);
                if (grant0 || grant1) begin
                    ownerD     = grant1;
                    lastGrantD = grant1;
                    subD       = grant1 ? r1_req_sub : r0_req_sub;
                    aD         = grant1 ? r1_req_a : r0_req_a;
                    bD         = grant1 ? r1_req_b : r0_req_b;
                    stateD     = StIssue;
                end
            end
            StIssue: begin
                cntD   = '0;
                stateD = StWait;
            end
            StWait: begin
                if (dp_done) begin
                    resultD = dp_result;
                    errD    = 1'b0;
                    stateD  = StResp;
                end else if (cntQ == TimeoutVal) begin
                    resultD = '0;
                    errD    = 1'b1;
                    stateD  = StResp;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            StResp: begin
                if (ownerRspReady) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ     <= StIdle;
            ownerQ     <= 1'b0;
            lastGrantQ <= 1'b1;
            cntQ       <= '0;
            resultQ    <= '0;
            errQ       <= 1'b0;
            subQ       <= 1'b0;
            aQ         <= '0;
            bQ         <= '0;
        end else begin
            stateQ     <= stateD;
            ownerQ     <= ownerD;
            lastGrantQ <= lastGrantD;
            cntQ       <= cntD;
            resultQ    <= resultD;
            errQ       <= errD;
            subQ       <= subD;
            aQ         <= aD;
            bQ         <= bD;
        end
    end

    assign r0_req_ready  = grant0;
    assign r1_req_ready  = grant1;
    assign r0_rsp_valid  = (stateQ == StResp) & ~ownerQ;
    assign r1_rsp_valid  = (stateQ == StResp) & ownerQ;
    assign r0_rsp_result = r0_rsp_valid ? resultQ : '0;
    assign r1_rsp_result = r1_rsp_valid ? resultQ : '0;
    assign r0_rsp_err    = r0_rsp_valid & errQ;
    assign r1_rsp_err    = r1_rsp_valid & errQ;

    assign dp_start    = (stateQ == StIssue);
    assign dp_subtract = subQ;
    assign dp_a        = aQ;
    assign dp_b        = bQ;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with a 3-cycle datapath model that can be
// told to hang so the watchdog path is exercised.
module tb_adder_arbiter;

    localparam int unsigned OPW     = 1027;
    localparam int unsigned RESW    = 1028;
    localparam int unsigned TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            r0_req_valid = 1'b0, r0_req_sub = 1'b0, r0_rsp_ready = 1'b1;
    logic            r1_req_valid = 1'b0, r1_req_sub = 1'b0, r1_rsp_ready = 1'b1;
    logic [OPW-1:0]  r0_req_a = '0, r0_req_b = '0, r1_req_a = '0, r1_req_b = '0;
    logic            r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid;
    logic            r0_rsp_err, r1_rsp_err;
    logic [RESW-1:0] r0_rsp_result, r1_rsp_result;
    logic            dp_start, dp_subtract, dp_done;
    logic [OPW-1:0]  dp_a, dp_b;
    logic [RESW-1:0] dp_result;

    logic            dpHang = 1'b0;
    logic            s1, s2, doneQ;
    int              nChecks = 0;
    int              nErrors = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.OPW(OPW), .RESW(RESW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_sub(r0_req_sub),
        .r0_req_a(r0_req_a), .r0_req_b(r0_req_b), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_result(r0_rsp_result), .r0_rsp_err(r0_rsp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_sub(r1_req_sub),
        .r1_req_a(r1_req_a), .r1_req_b(r1_req_b), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_result(r1_rsp_result), .r1_rsp_err(r1_rsp_err),
        .dp_start(dp_start), .dp_subtract(dp_subtract), .dp_a(dp_a), .dp_b(dp_b),
        .dp_result(dp_result), .dp_done(dp_done)
    );

    // Datapath model: done three cycles after start is sampled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0; s2 <= 1'b0; doneQ <= 1'b0;
        end else begin
            s1 <= dp_start & ~dpHang; s2 <= s1; doneQ <= s2;
        end
    end
    assign dp_done   = doneQ;
    assign dp_result = dp_subtract ? ({1'b0, dp_a} - {1'b0, dp_b}) : ({1'b0, dp_a} + {1'b0, dp_b});

    task automatic checkEq(input string tag, input logic [RESW-1:0] got, input logic [RESW-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got %h..%h exp %h..%h", tag, got[RESW-1:RESW-64], got[63:0],
                     exp[RESW-1:RESW-64], exp[63:0]);
        end
    endtask

    task automatic applyReset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Drive a request and return #1 after the accepting edge.
    task automatic issue(input int port, input logic sub, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic seen;
        seen = 1'b0;
        if (port == 0) begin
            r0_req_sub = sub; r0_req_a = a; r0_req_b = b; r0_req_valid = 1'b1;
        end else begin
            r1_req_sub = sub; r1_req_a = a; r1_req_b = b; r1_req_valid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((port == 0) ? r0_req_ready : r1_req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checkEq("accept", seen, 1'b1);
        @(posedge clk);
        #1;
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
    endtask

    // Call #1 after the accepting edge; returns at the negedge of the first response cycle.
    task automatic waitRsp(input int port, input int expLat, input logic [RESW-1:0] expRes,
                           input logic expErr);
        int n, starts, other;
        logic myValid;
        n = 0; starts = 0; other = 0; myValid = 1'b0;
        while (n < 60 && !myValid) begin
            @(negedge clk);
            n++;
            if (dp_start) starts++;
            if ((port == 0) ? r1_rsp_valid : r0_rsp_valid) other++;
            myValid = (port == 0) ? r0_rsp_valid : r1_rsp_valid;
        end
        checkEq("rspLatency", n, expLat);
        checkEq("rspResult", (port == 0) ? r0_rsp_result : r1_rsp_result, expRes);
        checkEq("rspErr", (port == 0) ? r0_rsp_err : r1_rsp_err, expErr);
        checkEq("startPulses", starts, 1);
        checkEq("otherRspValid", other, 0);
    endtask

    initial begin
        int got, bad, hv, hr, hq, hs;
        logic [RESW-1:0] minusTwo;
        minusTwo = {RESW{1'b1}} - 1'b1;

        applyReset();
        @(negedge clk);
        checkEq("rstStart", dp_start, 1'b0);
        checkEq("rstRspValid", {r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err}, 4'b0);
        checkEq("rstOperands", {dp_subtract, dp_a, dp_b} == '0, 1'b1);
        checkEq("rstResult", r0_rsp_result | r1_rsp_result, '0);

        // Port 0 add.
        issue(0, 1'b0, 5, 3);
        waitRsp(0, 5, 8, 1'b0);
        @(posedge clk); #1;

        // Port 1 subtract, both signs.
        issue(1, 1'b1, 5, 3);
        waitRsp(1, 5, 2, 1'b0);
        @(posedge clk); #1;
        issue(1, 1'b1, 3, 5);
        waitRsp(1, 5, minusTwo, 1'b0);
        @(posedge clk); #1;

        // Both ports valid continuously from reset: 0,1,0,1.
        applyReset();
        r0_req_sub = 1'b0; r0_req_a = 10; r0_req_b = 1;
        r1_req_sub = 1'b0; r1_req_a = 20; r1_req_b = 2;
        r0_req_valid = 1'b1; r1_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = -1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (r0_req_ready) begin got = 0; break; end
                if (r1_req_ready) begin got = 1; break; end
            end
            checkEq("rrGrant", got, i % 2);
            @(posedge clk); #1;
            if (i == 3) begin r0_req_valid = 1'b0; r1_req_valid = 1'b0; end
            waitRsp((got == 1) ? 1 : 0, 5, (got == 1) ? 22 : 11, 1'b0);
            @(posedge clk); #1;
        end

        // Response backpressure for 10 cycles with port 1 requesting meanwhile.
        r0_rsp_ready = 1'b0;
        issue(0, 1'b0, 7, 9);
        waitRsp(0, 5, 16, 1'b0);
        r1_req_sub = 1'b0; r1_req_a = 1; r1_req_b = 1; r1_req_valid = 1'b1;
        hv = 0; hr = 0; hq = 0; hs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!r0_rsp_valid) hv++;
            if (r0_rsp_result !== RESW'(16)) hr++;
            if (r0_req_ready || r1_req_ready) hq++;
            if (dp_start) hs++;
        end
        checkEq("holdValid", hv, 0);
        checkEq("holdResult", hr, 0);
        checkEq("holdReqReady", hq, 0);
        checkEq("holdStart", hs, 0);
        @(posedge clk); #1 r0_rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkEq("releaseIdle", {r1_req_ready, r0_rsp_valid}, 2'b10);
        @(posedge clk); #1 r1_req_valid = 1'b0;
        waitRsp(1, 5, 2, 1'b0);
        @(posedge clk); #1;

        // Hung datapath: watchdog error, then normal recovery.
        dpHang = 1'b1;
        issue(0, 1'b0, 4, 4);
        waitRsp(0, TIMEOUT + 3, '0, 1'b1);
        @(posedge clk); #1 dpHang = 1'b0;
        issue(0, 1'b0, 4, 4);
        waitRsp(0, 5, 8, 1'b0);
        @(posedge clk); #1;

        // Reset pulsed during WAIT.
        issue(1, 1'b1, 100, 23);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b0; r0_req_valid = 1'b1;
        #1;
        checkEq("midRstOperands", {dp_subtract, dp_a, dp_b} == '0, 1'b1);
        checkEq("midRstOutputs", {dp_start, r0_rsp_valid, r1_rsp_valid, r1_rsp_err}, 4'b0);
        checkEq("midRstIdle", r0_req_ready, 1'b1);
        r0_req_valid = 1'b0;
        @(negedge clk) resetn = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r0_rsp_valid || r1_rsp_valid || dp_start) bad++;
        end
        checkEq("noStaleRsp", bad, 0);
        @(posedge clk); #1;
        issue(0, 1'b0, 100, 23);
        waitRsp(0, 5, 123, 1'b0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
